// File: rtl/dvs_fifo_bus_scheduler_if.sv
// Bus bundle between the FIFO event-queue scheduler and its AER writers, RAVENS reader and queue flags.
// The scheduler uses the slave view; the masters and queue status side use the master view.
interface dvs_fifo_bus_scheduler_if #(
    parameter int NUM_WR     = 2,
    parameter int COUNT_BITS = 5
);
    logic [NUM_WR-1:0]     req_wr;
    logic                  req_rd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [COUNT_BITS-1:0] fifo_count;
    logic [NUM_WR-1:0]     grant_wr;
    logic                  grant_rd;
    logic                  bus_busy;

    modport master (
        output req_wr, req_rd, fifo_full, fifo_empty, fifo_count,
        input  grant_wr, grant_rd, bus_busy
    );

    modport slave (
        input  req_wr, req_rd, fifo_full, fifo_empty, fifo_count,
        output grant_wr, grant_rd, bus_busy
    );
endinterface

// File: rtl/dvs_fifo_bus_scheduler.sv
// Registered bus scheduler: NUM_WR round-robin AER writers plus one RAVENS reader sharing the event
// queue, one exclusive capped-length grant at a time, reader favoured at or above the high-water mark.
module dvs_fifo_bus_scheduler #(
    parameter int NUM_WR     = 2,
    parameter int COUNT_BITS = 5,
    parameter int HIGH_WATER = 12,
    parameter int BURST_MAX  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    dvs_fifo_bus_scheduler_if.slave     bus
);
    localparam int PTR_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_e;

    state_e              state_q,     state_d;
    logic [NUM_WR-1:0]   grant_wr_q,  grant_wr_d;
    logic                grant_rd_q,  grant_rd_d;
    logic                bus_busy_q,  bus_busy_d;
    logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [PTR_W-1:0]    wr_idx_q,    wr_idx_d;
    logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic                last_rd_q,   last_rd_d;

    logic [NUM_WR-1:0]   wr_elig;
    logic                rd_elig;
    logic                high_water;
    logic                burst_left;
    logic                wr_found;
    logic [PTR_W-1:0]    wr_pick;
    logic                take_rd;
    logic [PTR_W-1:0]    wr_idx_next;

    assign wr_elig     = bus.req_wr & {NUM_WR{~bus.fifo_full}};
    assign rd_elig     = bus.req_rd & ~bus.fifo_empty;
    assign high_water  = bus.fifo_count >= COUNT_BITS'(HIGH_WATER);
    assign burst_left  = burst_cnt_q < CNT_W'(BURST_MAX);
    assign wr_idx_next = (wr_idx_q == PTR_W'(NUM_WR - 1)) ? '0 : wr_idx_q + 1'b1;

    // Reader wins on high water, or when the last grant went to a writer; otherwise only when no writer wants the bus.
    assign take_rd = rd_elig && (high_water || !last_rd_q || !wr_found);

    // First eligible writer searching upward from rr_ptr with wrap.
    always_comb begin
        int idx;
        idx      = 0;
        wr_found = 1'b0;
        wr_pick  = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_WR) idx = idx - NUM_WR;
            if (!wr_found && wr_elig[idx[PTR_W-1:0]]) begin
                wr_found = 1'b1;
                wr_pick  = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
        state_d     = state_q;
        grant_wr_d  = grant_wr_q;
        grant_rd_d  = grant_rd_q;
        rr_ptr_d    = rr_ptr_q;
        wr_idx_d    = wr_idx_q;
        burst_cnt_d = burst_cnt_q;
        last_rd_d   = last_rd_q;

        unique case (state_q)
            S_IDLE: begin
                if (take_rd) begin
                    state_d     = S_RD;
                    grant_rd_d  = 1'b1;
                    burst_cnt_d = CNT_W'(1);
                end else if (wr_found) begin
                    state_d     = S_WR;
                    grant_wr_d  = NUM_WR'(1) << wr_pick;
                    wr_idx_d    = wr_pick;
                    burst_cnt_d = CNT_W'(1);
                end
            end
            S_WR: begin
                if (wr_elig[wr_idx_q] && burst_left) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    state_d     = S_IDLE;
                    grant_wr_d  = '0;
                    rr_ptr_d    = wr_idx_next;
                    last_rd_d   = 1'b0;
                    burst_cnt_d = '0;
                end
            end
            S_RD: begin
                if (rd_elig && burst_left) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end else begin
                    state_d     = S_IDLE;
                    grant_rd_d  = 1'b0;
                    last_rd_d   = 1'b1;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                grant_wr_d = '0;
                grant_rd_d = 1'b0;
            end
        endcase

        bus_busy_d = (|grant_wr_d) | grant_rd_d;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_wr_q  <= '0;
            grant_rd_q  <= 1'b0;
            bus_busy_q  <= 1'b0;
            rr_ptr_q    <= '0;
            wr_idx_q    <= '0;
            burst_cnt_q <= '0;
            last_rd_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_wr_q  <= grant_wr_d;
            grant_rd_q  <= grant_rd_d;
            bus_busy_q  <= bus_busy_d;
            rr_ptr_q    <= rr_ptr_d;
            wr_idx_q    <= wr_idx_d;
            burst_cnt_q <= burst_cnt_d;
            last_rd_q   <= last_rd_d;
        end
    end

    assign bus.grant_wr = grant_wr_q;
    assign bus.grant_rd = grant_rd_q;
    assign bus.bus_busy = bus_busy_q;
endmodule
